coproc0_unit: RTL

//  System coprocessor 0 for the unpipelined MIPS32 core. Responder to the control path's
//  CP0 flags: o_mc0 (mfc0), o_coproc0_we (mtc0), o_eret, o_coproc0_invalid_instr and

---
 rtl/coproc0_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/coproc0_unit.sv
// ============================================================================
//  Module      : coproc0_unit
//  Description : System coprocessor 0 for the unpipelined MIPS32 core.
//                Holds Count/Compare/Status/Cause/EPC, arbitrates exceptions
//                and interrupts, and drives the PC redirect / kill request
//                back to the datapath. Outputs decode the current cycle
//                combinationally; CP0 state updates on the rising edge.
//  Ports       : i_clk, i_rst            clock, synchronous active-high reset
//                i_mc0, i_coproc0_we     mfc0 / mtc0 in current instruction
//                i_eret                  eret in current instruction
//                i_invalid_instr         reserved-instruction flag
//                i_overflow              qualified arithmetic overflow
//                i_reg_addr, i_wdata     CP0 register number, mtc0 data
//                i_pc                    PC of current instruction
//                i_hw_irq                level-sensitive hardware interrupts
//                o_rdata                 mfc0 read data
//                o_redirect, o_redirect_pc  next-PC override
//                o_kill                  suppress writes of current instr
//                o_exl                   Status.EXL
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coproc0_unit #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180,
  parameter logic [31:0] STATUS_RESET  = 32'h0000_0000,
  parameter logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mc0,
  input  logic        i_coproc0_we,
  input  logic        i_eret,
  input  logic        i_invalid_instr,
  input  logic        i_overflow,
  input  logic [4:0]  i_reg_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_hw_irq,
  output logic [31:0] o_rdata,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_kill,
  output logic        o_exl
);

  // Only IM[15:8], EXL[1] and IE[0] exist in Status
  localparam logic [31:0] c_status_mask = 32'h0000_FF03;

  localparam logic [4:0] c_reg_count   = 5'd9;
  localparam logic [4:0] c_reg_compare = 5'd11;
  localparam logic [4:0] c_reg_status  = 5'd12;
  localparam logic [4:0] c_reg_cause   = 5'd13;
  localparam logic [4:0] c_reg_epc     = 5'd14;

  localparam logic [4:0] c_exc_int = 5'd0;
  localparam logic [4:0] c_exc_ri  = 5'd10;
  localparam logic [4:0] c_exc_ov  = 5'd12;

  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] status_q,   status_d;
  logic [7:0]  ip_q,       ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q,      epc_d;

  logic        w_ie;
  logic        w_exl;
  logic [7:0]  w_im;
  logic        w_irq_take;
  logic        w_exc_take;
  logic [4:0]  w_exc_code;
  logic        w_mtc0_commit;
  logic [31:0] w_cause;

  // --------------------------------------------------------------------------
  // Event arbitration: invalid > overflow > interrupt > eret > mtc0
  // --------------------------------------------------------------------------
  always_comb begin
    w_ie       = status_q[0];
    w_exl      = status_q[1];
    w_im       = status_q[15:8];
    w_irq_take = w_ie & ~w_exl & (|(ip_q & w_im));
    w_exc_take = i_invalid_instr | i_overflow | w_irq_take;

    if (i_invalid_instr) begin
      w_exc_code = c_exc_ri;
    end else if (i_overflow) begin
      w_exc_code = c_exc_ov;
    end else begin
      w_exc_code = c_exc_int;
    end

    // A killed instruction must not leave its mtc0 behind
    w_mtc0_commit = i_coproc0_we & ~w_exc_take;

    o_redirect    = w_exc_take | i_eret;
    o_redirect_pc = w_exc_take ? EXC_VECTOR : epc_q;
    o_kill        = w_exc_take;
    o_exl         = w_exl;
  end

  // --------------------------------------------------------------------------
  // Read path: pre-edge register values, so mfc0+mtc0 of one reg reads old
  // --------------------------------------------------------------------------
  always_comb begin
    w_cause = {16'h0000, ip_q, 1'b0, exc_code_q, 2'b00};
    o_rdata = 32'h0000_0000;
    if (i_mc0) begin
      case (i_reg_addr)
        c_reg_count:   o_rdata = count_q;
        c_reg_compare: o_rdata = compare_q;
        c_reg_status:  o_rdata = status_q;
        c_reg_cause:   o_rdata = w_cause;
        c_reg_epc:     o_rdata = epc_q;
        default:       o_rdata = 32'h0000_0000;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q + 32'd1;
    compare_d  = compare_q;
    status_d   = status_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // Hardware lines are resampled every edge; IP7 and IP[1:0] are sticky
    ip_d       = {ip_q[7], i_hw_irq, ip_q[1:0]};

    if (count_q == compare_q) begin
      ip_d[7] = 1'b1;
    end

    if (w_mtc0_commit) begin
      case (i_reg_addr)
        c_reg_count:   count_d = i_wdata;
        c_reg_compare: begin
          compare_d = i_wdata;
          ip_d[7]   = 1'b0;          // acknowledge beats a fresh match
        end
        c_reg_status:  status_d   = i_wdata & c_status_mask;
        c_reg_cause:   ip_d[1:0]  = i_wdata[9:8];
        c_reg_epc:     epc_d      = i_wdata;
        default:       ;
      endcase
    end

    if (w_exc_take) begin
      exc_code_d = w_exc_code;
      // Nested exception keeps the original return address
      if (!w_exl) begin
        epc_d = i_pc;
      end
      status_d[1] = 1'b1;
    end else if (i_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= 32'h0000_0000;
      compare_q  <= COMPARE_RESET;
      status_q   <= STATUS_RESET & c_status_mask;
      ip_q       <= 8'h00;
      exc_code_q <= 5'd0;
      epc_q      <= 32'h0000_0000;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

`default_nettype wire
